// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared constants for the FIFO-buffered UART.
// Holds the register addresses, the STATUS/CTRL bit positions and the
// frame state type used by both the transmit and receive FSMs.
package uart_fifo_pkg;

    // Register addresses on the 2-bit CPU address bus
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL    = 7;
    localparam int ST_TX_IDLE    = 6;
    localparam int ST_RX_AVAIL   = 5;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_PARITY_ERR = 2;

    // CTRL bit positions
    localparam int CT_TWO_STOP = 0;
    localparam int CT_PAR_EN   = 1;
    localparam int CT_PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_fifo_sync_fifo.sv
// uart_sync_fifo: single-clock first-word-fall-through FIFO.
// dout always shows the oldest entry while the FIFO is non-empty. A push
// on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    // Storage array: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally; count tracks occupancy for full/empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: full-duplex UART with TX/RX FIFOs on a 4-register CPU bus.
// Optional parity support is compiled in with `define UART_FIFO_PARITY_EN;
// without it CTRL bits 1..2 stay 0, so the PARITY states are never entered
// and parity_err can never be raised.
module uart_fifo #(
    parameter int CLK_HZ    = 1152000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] dbw,
    output logic [7:0] dbr,
    output logic       tx,
    input  logic       rx
);
    import uart_fifo_pkg::*;

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam int BIT_W   = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    // ---------------- CPU bus decode ----------------
    logic rd_en, wr_en, tx_push, rx_pop, status_rd;
    assign rd_en     = cs && !we;
    assign wr_en     = cs && we;
    assign tx_push   = wr_en && (addr == ADDR_DATA);
    assign rx_pop    = rd_en && (addr == ADDR_DATA);
    assign status_rd = rd_en && (addr == ADDR_STATUS);

    logic [2:0] ctrl_reg;

    // CTRL register; parity bits only exist when parity is compiled in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_reg <= '0;
        end else if (wr_en && (addr == ADDR_CTRL)) begin
            ctrl_reg[CT_TWO_STOP] <= dbw[CT_TWO_STOP];
`ifdef UART_FIFO_PARITY_EN
            ctrl_reg[CT_PAR_EN]   <= dbw[CT_PAR_EN];
            ctrl_reg[CT_PAR_ODD]  <= dbw[CT_PAR_ODD];
`else
            ctrl_reg[CT_PAR_ODD:CT_PAR_EN] <= 2'b00;
`endif
        end
    end

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] tx_dout, rx_dout, rx_shift_reg;
    logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_done;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
        .din(dbw[DATA_BITS-1:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_done), .pop(rx_pop),
        .din(rx_shift_reg), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- Transmitter ----------------
    uart_state_t          tx_state_reg, tx_state_next;
    logic [CNT_W-1:0]     tx_cnt_reg, tx_cnt_next;
    logic [BIT_W-1:0]     tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic tx_par_reg, tx_par_next, tx_two_stop_reg, tx_two_stop_next;
    logic tx_par_en_reg, tx_par_en_next, tx_stop2_reg, tx_stop2_next;
    logic tx_reg, tx_next, tx_load, tx_bit_done;

    assign tx_bit_done = (tx_cnt_reg == CNT_LAST);

    // TX next-state: frame sequencing, FIFO pop and line level for the next cycle
    always_comb begin
        tx_state_next    = tx_state_reg;
        tx_cnt_next      = tx_cnt_reg + 1'b1;
        tx_bit_next      = tx_bit_reg;
        tx_shift_next    = tx_shift_reg;
        tx_par_next      = tx_par_reg;
        tx_two_stop_next = tx_two_stop_reg;
        tx_par_en_next   = tx_par_en_reg;
        tx_stop2_next    = tx_stop2_reg;
        tx_load          = 1'b0;
        tx_pop           = 1'b0;
        tx_next          = 1'b1;
        case (tx_state_reg)
            IDLE: begin
                tx_cnt_next = '0;
                tx_load     = !tx_empty;
            end
            START: if (tx_bit_done) begin
                tx_cnt_next   = '0;
                tx_bit_next   = '0;
                tx_state_next = DATA;
            end
            DATA: if (tx_bit_done) begin
                tx_cnt_next = '0;
                if (tx_bit_reg == BIT_LAST) begin
                    tx_state_next = tx_par_en_reg ? PARITY : STOP;
                    tx_stop2_next = 1'b0;
                end else begin
                    tx_bit_next   = tx_bit_reg + 1'b1;
                    tx_shift_next = tx_shift_reg >> 1;
                end
            end
            PARITY: if (tx_bit_done) begin
                tx_cnt_next   = '0;
                tx_state_next = STOP;
                tx_stop2_next = 1'b0;
            end
            STOP: if (tx_bit_done) begin
                tx_cnt_next = '0;
                if (tx_two_stop_reg && !tx_stop2_reg) begin
                    tx_stop2_next = 1'b1;
                end else if (!tx_empty) begin
                    tx_load = 1'b1;
                end else begin
                    tx_state_next = IDLE;
                end
            end
            default: tx_state_next = IDLE;
        endcase
        // Pop the next word into the shifter and latch CTRL for this frame
        if (tx_load) begin
            tx_pop           = 1'b1;
            tx_shift_next    = tx_dout;
            tx_par_next      = (^tx_dout) ^ ctrl_reg[CT_PAR_ODD];
            tx_two_stop_next = ctrl_reg[CT_TWO_STOP];
            tx_par_en_next   = ctrl_reg[CT_PAR_EN];
            tx_cnt_next      = '0;
            tx_state_next    = START;
        end
        case (tx_state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = tx_shift_next[0];
            PARITY:  tx_next = tx_par_next;
            default: tx_next = 1'b1;
        endcase
    end

    // TX state register; the line output is registered to keep the pin glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_reg    <= IDLE;
            tx_cnt_reg      <= '0;
            tx_bit_reg      <= '0;
            tx_shift_reg    <= '0;
            tx_par_reg      <= 1'b0;
            tx_two_stop_reg <= 1'b0;
            tx_par_en_reg   <= 1'b0;
            tx_stop2_reg    <= 1'b0;
            tx_reg          <= 1'b1;
        end else begin
            tx_state_reg    <= tx_state_next;
            tx_cnt_reg      <= tx_cnt_next;
            tx_bit_reg      <= tx_bit_next;
            tx_shift_reg    <= tx_shift_next;
            tx_par_reg      <= tx_par_next;
            tx_two_stop_reg <= tx_two_stop_next;
            tx_par_en_reg   <= tx_par_en_next;
            tx_stop2_reg    <= tx_stop2_next;
            tx_reg          <= tx_next;
        end
    end

    assign tx = tx_reg;

    // ---------------- Receiver ----------------
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    uart_state_t          rx_state_reg, rx_state_next;
    logic [CNT_W-1:0]     rx_cnt_reg, rx_cnt_next;
    logic [BIT_W-1:0]     rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_next;
    logic rx_par_en_reg, rx_par_en_next, rx_par_odd_reg, rx_par_odd_next;
    logic rx_par_bad_reg, rx_par_bad_next, rx_bit_done, frame_evt;

    assign rx_bit_done = (rx_cnt_reg == CNT_LAST);

    // RX next-state: start validation at half a bit, then one sample per bit period
    always_comb begin
        rx_state_next   = rx_state_reg;
        rx_cnt_next     = rx_cnt_reg + 1'b1;
        rx_bit_next     = rx_bit_reg;
        rx_shift_next   = rx_shift_reg;
        rx_par_en_next  = rx_par_en_reg;
        rx_par_odd_next = rx_par_odd_reg;
        rx_par_bad_next = rx_par_bad_reg;
        rx_done         = 1'b0;
        frame_evt       = 1'b0;
        case (rx_state_reg)
            IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_state_next   = START;
                    rx_par_en_next  = ctrl_reg[CT_PAR_EN];
                    rx_par_odd_next = ctrl_reg[CT_PAR_ODD];
                    rx_par_bad_next = 1'b0;
                end
            end
            START: if (rx_cnt_reg == CNT_HALF) begin
                rx_cnt_next   = '0;
                rx_bit_next   = '0;
                rx_state_next = rx_sync_reg ? IDLE : DATA;
            end
            DATA: if (rx_bit_done) begin
                rx_cnt_next   = '0;
                rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                if (rx_bit_reg == BIT_LAST) begin
                    rx_state_next = rx_par_en_reg ? PARITY : STOP;
                end else begin
                    rx_bit_next = rx_bit_reg + 1'b1;
                end
            end
            PARITY: if (rx_bit_done) begin
                rx_cnt_next     = '0;
                rx_par_bad_next = rx_sync_reg ^ (^rx_shift_reg) ^ rx_par_odd_reg;
                rx_state_next   = STOP;
            end
            STOP: if (rx_bit_done) begin
                rx_cnt_next   = '0;
                rx_done       = 1'b1;
                frame_evt     = !rx_sync_reg;
                rx_state_next = IDLE;
            end
            default: rx_state_next = IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_reg   <= IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_en_reg  <= 1'b0;
            rx_par_odd_reg <= 1'b0;
            rx_par_bad_reg <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            rx_cnt_reg     <= rx_cnt_next;
            rx_bit_reg     <= rx_bit_next;
            rx_shift_reg   <= rx_shift_next;
            rx_par_en_reg  <= rx_par_en_next;
            rx_par_odd_reg <= rx_par_odd_next;
            rx_par_bad_reg <= rx_par_bad_next;
        end
    end

    // ---------------- Status flags and read port ----------------
    logic overrun_reg, frame_err_reg, parity_err_reg, overrun_evt, parity_evt;
    // A simultaneous CPU pop frees the slot, so that case is not an overrun
    assign overrun_evt = rx_done && rx_full && !rx_pop;
    assign parity_evt  = rx_done && rx_par_bad_reg;

    // Sticky error flags: cleared by a STATUS read unless re-raised that cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            overrun_reg    <= overrun_evt || (overrun_reg && !status_rd);
            frame_err_reg  <= frame_evt   || (frame_err_reg && !status_rd);
            parity_err_reg <= parity_evt  || (parity_err_reg && !status_rd);
        end
    end

    logic [7:0] rx_word, status_word, ctrl_word, dbr_reg, dbr_next;

    // Read mux; dbr returns to 0 on any cycle without a read
    always_comb begin
        rx_word                    = '0;
        rx_word[DATA_BITS-1:0]     = rx_dout;
        status_word                = '0;
        status_word[ST_TX_FULL]    = tx_full;
        status_word[ST_TX_IDLE]    = tx_empty && (tx_state_reg == IDLE);
        status_word[ST_RX_AVAIL]   = !rx_empty;
        status_word[ST_RX_OVERRUN] = overrun_reg;
        status_word[ST_FRAME_ERR]  = frame_err_reg;
        status_word[ST_PARITY_ERR] = parity_err_reg;
        ctrl_word                  = '0;
        ctrl_word[2:0]             = ctrl_reg;
        dbr_next                   = '0;
        if (rd_en) begin
            case (addr)
                ADDR_DATA:   dbr_next = rx_empty ? 8'h00 : rx_word;
                ADDR_STATUS: dbr_next = status_word;
                ADDR_CTRL:   dbr_next = ctrl_word;
                ADDR_RSVD:   dbr_next = 8'h00;
            endcase
        end
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbr_reg <= '0;
        end else begin
            dbr_reg <= dbr_next;
        end
    end

    assign dbr = dbr_reg;

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: scoreboard bench for uart_fifo at BIT_CYC = 10.
// Stimulus pushes expected read data and expected TX frames into queues;
// independent monitors compare dbr after each read and decode every frame
// seen on tx. Build with +define+UART_FIFO_PARITY_EN to add the parity case.
module tb_uart_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] dbw = 8'h00;
    logic [7:0] dbr;
    logic       tx;
    logic       rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rd_seen = 1'b0;

    typedef struct { logic [7:0] val; string name; } rd_exp_t;
    typedef struct { logic [7:0] data; bit b2b; } tx_exp_t;
    rd_exp_t rd_q[$];
    tx_exp_t tx_q[$];

    uart_fifo #(
        .CLK_HZ(1152000), .BAUD(115200), .DATA_BITS(8), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr),
        .dbw(dbw), .dbr(dbr), .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= cs && !we;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; dbw = d;
        tick();
        cs = 1'b0; we = 1'b0; dbw = 8'h00;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
        rd_q.push_back('{e, nm});
        cs = 1'b1; we = 1'b0; addr = a;
        tick();
        cs = 1'b0;
    endtask

    task automatic tx_expect(input logic [7:0] d, input bit b2b);
        tx_q.push_back('{d, b2b});
    endtask

    // Drive one frame on rx: start, 8 data LSB first, optional parity, one stop
    task automatic rx_frame(input logic [7:0] d, input int par, input logic stop);
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(10);
        end
        if (par >= 0) begin
            rx = par[0];
            tick(10);
        end
        rx = stop;
        tick(10);
        rx = 1'b1;
        tick(2);
    endtask

    // Read monitor: compare dbr the cycle after each read, expect 0 otherwise
    initial begin : rd_mon
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected got=%02h", dbr);
                end else begin
                    e = rd_q.pop_front();
                    $display("RD %-14s dbr=%02h expected=%02h", e.name, dbr, e.val);
                    chk(e.name, {24'h0, dbr}, {24'h0, e.val});
                end
            end else begin
                chk("dbr_idle", {24'h0, dbr}, 32'h0);
            end
        end
    end

    // TX monitor: every bit must hold its value for all 10 cycles
    initial begin : tx_mon
        tx_exp_t e;
        logic [9:0] fb;
        logic [7:0] got;
        int bad;
        int start_cyc;
        int prev_start;
        prev_start = -1000;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                start_cyc = cyc;
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected frame at cycle %0d", cyc);
                    e = '{8'h00, 1'b0};
                end else begin
                    e = tx_q.pop_front();
                end
                fb  = {1'b1, e.data, 1'b0};
                bad = 0;
                got = 8'h00;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < 10; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (tx !== fb[b]) bad++;
                        if (s == 5 && b >= 1 && b <= 8) got[b-1] = tx;
                    end
                end
                $display("TX frame %02h expected=%02h at cycle %0d", got, e.data, start_cyc);
                chk("tx_data", {24'h0, got}, {24'h0, e.data});
                chk("tx_bit_shape", bad, 0);
                if (e.b2b) chk("tx_b2b_gap", start_cyc - prev_start, 100);
                prev_start = start_cyc;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        tick(4);
        rst_n = 1'b1;
        tick(2);

        // Reset state
        chk("tx_reset", {31'h0, tx}, 32'h1);
        rd(2'd1, 8'h40, "status_reset");
        rd(2'd0, 8'h00, "data_empty");
        rd(2'd2, 8'h00, "ctrl_reset");
        rd(2'd3, 8'h00, "addr3");

        // CTRL: parity bits only writable when parity is compiled in
        wr(2'd3, 8'hFF);
        rd(2'd3, 8'h00, "addr3_ignore");
        wr(2'd2, 8'hFF);
`ifdef UART_FIFO_PARITY_EN
        rd(2'd2, 8'h07, "ctrl_wr");
`else
        rd(2'd2, 8'h01, "ctrl_wr");
`endif
        wr(2'd2, 8'h00);
        rd(2'd2, 8'h00, "ctrl_clr");

        // Single TX frame of A5
        tx_expect(8'hA5, 1'b0);
        wr(2'd0, 8'hA5);
        tick(2);
        chk("tx_start_lat", {31'h0, tx}, 32'h0);
        rd(2'd1, 8'h00, "status_txbusy");
        tick(110);
        rd(2'd1, 8'h40, "status_txdone");

        // TX FIFO fill: one in the shifter, four queued, fifth dropped
        tx_expect(8'h81, 1'b0);
        wr(2'd0, 8'h81);
        tick(2);
        tx_expect(8'h42, 1'b1);
        wr(2'd0, 8'h42);
        tx_expect(8'h24, 1'b1);
        wr(2'd0, 8'h24);
        tx_expect(8'h18, 1'b1);
        wr(2'd0, 8'h18);
        tx_expect(8'hC3, 1'b1);
        wr(2'd0, 8'hC3);
        rd(2'd1, 8'h80, "status_txfull");
        wr(2'd0, 8'hEE);
        tick(120);
        rd(2'd1, 8'h00, "status_afterpop");
        tx_expect(8'h7E, 1'b1);
        wr(2'd0, 8'h7E);
        rd(2'd1, 8'h80, "status_refull");
        tick(600);
        rd(2'd1, 8'h40, "status_txdrain");

        // Single RX byte
        rx_frame(8'h3C, -1, 1'b1);
        rd(2'd1, 8'h60, "status_rxavail");
        rd(2'd0, 8'h3C, "rx_3c");
        rd(2'd1, 8'h40, "status_rxempty");

        // RX overrun: five frames into a 4-deep FIFO, TX kept busy meanwhile
        rx_frame(8'h11, -1, 1'b1);
        rx_frame(8'h22, -1, 1'b1);
        rx_frame(8'h33, -1, 1'b1);
        rx_frame(8'h44, -1, 1'b1);
        tx_expect(8'h0F, 1'b0);
        wr(2'd0, 8'h0F);
        tx_expect(8'hF0, 1'b1);
        wr(2'd0, 8'hF0);
        rx_frame(8'h55, -1, 1'b1);
        rd(2'd1, 8'h30, "status_overrun");
        rd(2'd0, 8'h11, "rx_11");
        rd(2'd0, 8'h22, "rx_22");
        rd(2'd0, 8'h33, "rx_33");
        rd(2'd0, 8'h44, "rx_44");
        rd(2'd0, 8'h00, "rx_underflow");
        rd(2'd1, 8'h00, "status_ovr_clr");
        tick(150);

        // Frame error: byte still stored, flag sticky until STATUS read
        rx_frame(8'h5A, -1, 1'b0);
        rd(2'd1, 8'h68, "status_frame");
        rd(2'd0, 8'h5A, "rx_5a_ferr");
        rd(2'd1, 8'h40, "status_fe_clr");

`ifdef UART_FIFO_PARITY_EN
        // Even parity, wrong parity bit and a zero stop bit
        wr(2'd2, 8'h02);
        rd(2'd2, 8'h02, "ctrl_par_even");
        rx_frame(8'h5A, 1, 1'b0);
        rd(2'd1, 8'h6C, "status_par_fe");
        rd(2'd0, 8'h5A, "rx_5a_perr");
        rd(2'd1, 8'h40, "status_pe_clr");
        wr(2'd2, 8'h00);
`endif

        // Short low glitch must not start a frame
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        rd(2'd1, 8'h40, "status_glitch");
        rd(2'd0, 8'h00, "rx_glitch");

        tick(5);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("tx_q_empty", tx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised successor to the single-buffer UART: full-duplex 8-bit-bus UART with a configurable data width, stop-bit count, TX and RX FIFOs, mid-bit-sampled receiver and sticky error flags. It sits on the CPU data bus as a 4-register peripheral, with `tx`/`rx` routed to pins.

## Interface
- `CLK_HZ`, default 1152000: master clock frequency in Hz.
- `BAUD`, default 115200: line rate. Bit period `BIT_CYC = CLK_HZ/BAUD`, which must be at least 4.
- `DATA_BITS`, default 8: frame data bits, legal range 5..8.
- `TX_DEPTH`, default 4: TX FIFO entries. Must be a power of 2, at least 2.
- `RX_DEPTH`, default 4: RX FIFO entries. Must be a power of 2, at least 2.
- `clk  in  1`: single clock. All logic is on its rising edge.
- `rst_n  in  1`: reset, synchronous and active-low.
- `cs  in  1`: chip select. Register access happens only when `cs`=1.
- `we  in  1`: 1 = write, 0 = read.
- `addr  in  2`: register select.
- `dbw  in  8`: write data.
- `dbr  out  8`: read data. Registered; 0 whenever no read occurred on the previous cycle.
- `tx  out  1`: serial output. Idles at 1.
- `rx  in  1`: serial input. Asynchronous to `clk`.

## Operation
- Register map:
  - addr 0 write: push `dbw[DATA_BITS-1:0]` into the TX FIFO.
  - addr 0 read: pop the RX FIFO. Upper bits read 0.
  - addr 1 read: STATUS. bit7 tx_full, bit6 tx_idle (FIFO empty and shifter idle), bit5 rx_avail, bit4 rx_overrun, bit3 frame_err, bit2 parity_err, bits1..0 = 0.
  - addr 2: CTRL, read/write. bit0 two_stop, bit1 par_en, bit2 par_odd, other bits 0.
  - addr 3: reads 0; writes are ignored.
- Reset values: `dbr`=0, `tx`=1, both FIFOs empty, CTRL=0, all flags 0, both FSMs IDLE.
- Write to a full TX FIFO: the data is dropped and the FIFO is unchanged. There is no flag; software polls tx_full.
- Read of an empty RX FIFO: returns 0, no pop.
- Reading STATUS clears bits 4..2. If an error event occurs in the same cycle as the clear, the flag stays set.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty; the word is popped into the shifter in the same cycle.
  - Data is sent LSB first, then parity (only if par_en), then 1 or 2 stop bits.
  - From STOP, go directly to START if the FIFO is non-empty (back-to-back frames), otherwise to IDLE.
- RX path: `rx` passes through a 2-flop synchroniser. RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on the synchronised input → START.
  - START: at `BIT_CYC/2` re-sample. If high, treat as a glitch and return to IDLE. If low, go to DATA.
  - DATA / PARITY / STOP: sample every `BIT_CYC` cycles thereafter.
  - Only the first stop bit is checked. A stop bit of 0 sets frame_err; the byte is still stored.
  - Parity mismatch sets parity_err; the byte is still stored.
  - Completed byte with the RX FIFO full: the byte is dropped and rx_overrun is set.
- Simultaneous events:
  - CPU pop and RX push in the same cycle on a full FIFO: both succeed, no overrun.
  - CPU push and TX pop in the same cycle on a full TX FIFO: the push succeeds.
- Writing CTRL mid-frame takes effect from the next frame. Each FSM latches CTRL on leaving IDLE.

## Timing
- Register read latency: 1 cycle. `dbr` is valid on the cycle after `cs & !we`.
- TX: `tx` drops to 0 at most 2 cycles after a write to an idle UART.
- TX: each bit lasts exactly `BIT_CYC` cycles.
- RX: the byte is visible (rx_avail=1) no later than `BIT_CYC/2 + 3` cycles after the centre of the stop bit.
- Baud counters: width `$clog2(BIT_CYC)`. They reset to 0 on every state transition and do not free-run in IDLE.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally. The count is `$clog2(DEPTH)+1` bits.
- `rst_n` low mid-frame: the next edge forces `tx`=1, FSMs to IDLE and FIFOs empty. The frame is truncated, not completed.

## Configuration
- `UART_FIFO_PARITY_EN` defined: CTRL bits 1..2, the PARITY states and parity_err are implemented.
- Not defined:
  - CTRL bits 1..2 read 0 and ignore writes.
  - The PARITY states are absent.
  - STATUS bit2 reads 0.
  - Frames are always 8N1/8N2-style (data width set by `DATA_BITS`).

## Structure
- Package `uart_fifo_pkg`:
  - register address constants
  - STATUS and CTRL bit-index constants
  - `uart_state_t` enum (IDLE, START, DATA, PARITY, STOP), shared by both FSMs
- Sub-module `uart_sync_fifo`: parameters `WIDTH` and `DEPTH`; ports push, pop, din, dout (first-word-fall-through), full, empty. Instantiated twice: TX with `DATA_BITS`, RX with `DATA_BITS`.

## Test plan
Bench defaults: `BIT_CYC`=10.
- Reset, then read addr 1 → `dbr`=8'h40; `tx` held 1.
- Write 8'hA5 to addr 0 → `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_idle returns to 1 afterwards.
- Write 5 bytes back-to-back with `TX_DEPTH`=4 and the line busy → the 5th is accepted only after the first pop; tx_full=1 while 4 bytes are pending; frames have no idle gap between them.
- Drive 8'h3C on `rx` at 115200 baud → rx_avail=1; read addr 0 → 8'h3C; rx_avail=0.
- Send 5 frames without reading (`RX_DEPTH`=4) → STATUS=8'h30 (rx_avail + rx_overrun); the 4 oldest bytes are read back; the second STATUS read has bit4=0.
- Macro on, CTRL=8'h02, inject a frame with wrong even parity and stop=0 → STATUS bits 3 and 2 = 1; the byte is still stored; a 3-cycle low glitch on `rx` produces no byte.
